// File: rtl/dcache_fill_unit.sv
// ============================================================================
// Module      : dcache_fill_unit
// Description : Direct-mapped write-through, no-write-allocate L1 data cache
//               with a single-outstanding miss/fill FSM. Optional hit/miss
//               counters are built when DCACHE_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_fill_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINES  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] lookup_addr,
    input  logic              data_missed1,
    output logic              data_ready1,
    output logic [DATA_W-1:0] data_response1,
    input  logic              st_valid,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              st_ready,
    output logic              mem_req_valid,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_misses
`endif
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - 2 - IDX_W;
    localparam int WA_W  = ADDR_W - 2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_REQ  = 2'd1,
        S_RD_WAIT = 2'd2,
        S_WR_REQ  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];
    logic [WA_W-1:0]   miss_addr_q;
    logic [WA_W-1:0]   st_addr_q;
    logic [DATA_W-1:0] st_data_q;

    logic [IDX_W-1:0]  lk_idx, st_idx, fill_idx;
    logic [TAG_W-1:0]  lk_tag, st_tag, fill_tag;
    logic              hit, miss_start, st_accept, st_hit, fill_done;
    logic              unused_addr_bits;

    assign lk_idx   = lookup_addr[2 +: IDX_W];
    assign lk_tag   = lookup_addr[ADDR_W-1 -: TAG_W];
    assign st_idx   = st_addr[2 +: IDX_W];
    assign st_tag   = st_addr[ADDR_W-1 -: TAG_W];
    assign fill_idx = miss_addr_q[0 +: IDX_W];
    assign fill_tag = miss_addr_q[WA_W-1 -: TAG_W];
    assign unused_addr_bits = ^{lookup_addr[1:0], st_addr[1:0]};

    assign hit            = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign data_ready1    = hit;
    assign data_response1 = hit ? data_q[lk_idx] : '0;

    // A pending miss wins over a store; this also blocks stores during a fill.
    assign miss_start = (state_q == S_IDLE) && data_missed1 && !hit;
    assign st_ready   = (state_q == S_IDLE) && !(data_missed1 && !hit);
    assign st_accept  = st_valid && st_ready;
    assign st_hit     = valid_q[st_idx] && (tag_q[st_idx] == st_tag);
    assign fill_done  = (state_q == S_RD_WAIT) && mem_resp_valid;

    always_comb begin
        state_d       = state_q;
        mem_req_valid = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        case (state_q)
            S_IDLE: begin
                if (miss_start) begin
                    state_d = S_RD_REQ;
                end else if (st_accept) begin
                    state_d = S_WR_REQ;
                end
            end
            S_RD_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {miss_addr_q, 2'b00};
                if (mem_req_ready) begin
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (mem_resp_valid) begin
                    state_d = S_IDLE;
                end
            end
            S_WR_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = {st_addr_q, 2'b00};
                mem_req_wdata = st_data_q;
                if (mem_req_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            valid_q     <= '0;
            miss_addr_q <= '0;
            st_addr_q   <= '0;
            st_data_q   <= '0;
        end else begin
            state_q <= state_d;
            if (fill_done) begin
                valid_q[fill_idx] <= 1'b1;
            end
            if (miss_start) begin
                miss_addr_q <= lookup_addr[ADDR_W-1:2];
            end
            if (st_accept) begin
                st_addr_q <= st_addr[ADDR_W-1:2];
                st_data_q <= st_data;
            end
        end
    end

    // Tag/data arrays carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= mem_resp_data;
        end else if (st_accept && st_hit) begin
            data_q[st_idx] <= st_data;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hits_q, misses_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else begin
            if (!data_missed1 && hit && (hits_q != 32'hFFFF_FFFF)) begin
                hits_q <= hits_q + 32'd1;
            end
            if (miss_start && (misses_q != 32'hFFFF_FFFF)) begin
                misses_q <= misses_q + 32'd1;
            end
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dcache_fill_unit.sv
// ============================================================================
// Module      : tb_dcache_fill_unit
// Description : Self-checking bench for dcache_fill_unit against an
//               array-based cache/memory model (stats checked if
//               DCACHE_STATS_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dcache_fill_unit;

    localparam int LINES = 16;
    localparam int IB    = $clog2(LINES);

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] lookup_addr = '0;
    logic        data_missed1 = 1'b0;
    logic        data_ready1;
    logic [31:0] data_response1;
    logic        st_valid = 1'b0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic        st_ready;
    logic        mem_req_valid;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_req_ready = 1'b0;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = '0;
`ifdef DCACHE_STATS_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;
`endif

    int total = 0;
    int bad   = 0;

    bit          m_valid [LINES];
    logic [31:0] m_tag   [LINES];
    logic [31:0] m_data  [LINES];
    logic [31:0] mem_model [int unsigned];

    dcache_fill_unit #(.ADDR_W(32), .DATA_W(32), .LINES(LINES)) dut (
        .clk            (clk),
        .reset          (reset),
        .lookup_addr    (lookup_addr),
        .data_missed1   (data_missed1),
        .data_ready1    (data_ready1),
        .data_response1 (data_response1),
        .st_valid       (st_valid),
        .st_addr        (st_addr),
        .st_data        (st_data),
        .st_ready       (st_ready),
        .mem_req_valid  (mem_req_valid),
        .mem_req_we     (mem_req_we),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
`ifdef DCACHE_STATS_EN
        ,
        .stat_hits      (stat_hits),
        .stat_misses    (stat_misses)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int unsigned m_index(input logic [31:0] a);
        return (a >> 2) % LINES;
    endfunction

    function automatic logic [31:0] m_tagof(input logic [31:0] a);
        return a >> (2 + IB);
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        return m_valid[m_index(a)] && (m_tag[m_index(a)] == m_tagof(a));
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        return m_hit(a) ? m_data[m_index(a)] : 32'h0;
    endfunction

    task automatic m_install(input logic [31:0] a, input logic [31:0] d);
        m_valid[m_index(a)] = 1'b1;
        m_tag[m_index(a)]   = m_tagof(a);
        m_data[m_index(a)]  = d;
    endtask

    task automatic m_store(input logic [31:0] a, input logic [31:0] d);
        if (m_hit(a)) m_data[m_index(a)] = d;
        mem_model[a >> 2] = d;
    endtask

    task automatic m_clear();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    endtask

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic serve_read(input logic [31:0] d, input int stall, input int lat,
                              output logic [31:0] got_addr, output logic got_we, output bit timeout);
        int n = 0;
        timeout = 1'b0;
        got_addr = '0;
        got_we = 1'b0;
        while (mem_req_valid !== 1'b1 && n < 20) begin tick(); n++; end
        if (mem_req_valid !== 1'b1) begin timeout = 1'b1; return; end
        got_addr = mem_req_addr;
        got_we   = mem_req_we;
        repeat (stall) tick();
        mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
        repeat (lat - 1) tick();
        mem_resp_valid = 1'b1; mem_resp_data = d; tick(); mem_resp_valid = 1'b0;
    endtask

    task automatic serve_write(input int stall, output logic [31:0] got_addr,
                               output logic got_we, output logic [31:0] got_wdata, output bit timeout);
        int n = 0;
        timeout = 1'b0;
        got_addr = '0;
        got_we = 1'b0;
        got_wdata = '0;
        while (mem_req_valid !== 1'b1 && n < 20) begin tick(); n++; end
        if (mem_req_valid !== 1'b1) begin timeout = 1'b1; return; end
        got_addr  = mem_req_addr;
        got_we    = mem_req_we;
        got_wdata = mem_req_wdata;
        repeat (stall) tick();
        mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b0; data_missed1 = 1'b0; st_valid = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        m_clear();
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        lookup_addr = 32'h40; #1;
        total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid got=%b exp=0", mem_req_valid); end
        total++; if (st_ready !== 1'b1) begin bad++; $display("FAIL rst_st_ready got=%b exp=1", st_ready); end
        total++; if (data_ready1 !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", data_ready1); end
        total++; if (data_response1 !== 32'h0) begin bad++; $display("FAIL rst_resp got=%h exp=0", data_response1); end
    endtask

    task automatic test_fill_basic();
        lookup_addr = 32'h40; data_missed1 = 1'b1; #1;
        total++; if (data_ready1 !== 1'b0) begin bad++; $display("FAIL fill_pre_ready got=%b exp=0", data_ready1); end
        total++; if (st_ready !== 1'b0) begin bad++; $display("FAIL fill_pre_st_ready got=%b exp=0", st_ready); end
        tick();
        total++; if (mem_req_valid !== 1'b1 || mem_req_we !== 1'b0 || mem_req_addr !== 32'h40) begin
            bad++; $display("FAIL fill_req got v=%b we=%b a=%h exp v=1 we=0 a=00000040", mem_req_valid, mem_req_we, mem_req_addr); end
        mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
        tick(); tick();
        total++; if (data_ready1 !== 1'b0) begin bad++; $display("FAIL fill_wait_ready got=%b exp=0", data_ready1); end
        mem_resp_valid = 1'b1; mem_resp_data = 32'hDEADBEEF; tick(); mem_resp_valid = 1'b0;
        data_missed1 = 1'b0; #1;
        m_install(32'h40, 32'hDEADBEEF);
        total++; if (data_ready1 !== 1'b1 || data_response1 !== m_read(32'h40)) begin
            bad++; $display("FAIL fill_hit got r=%b d=%h exp r=1 d=%h", data_ready1, data_response1, m_read(32'h40)); end
    endtask

    task automatic test_evict();
        logic [31:0] ga;
        logic gw;
        bit to;
        lookup_addr = 32'h80; data_missed1 = 1'b1; tick();
        serve_read(32'h12345678, 0, 2, ga, gw, to);
        data_missed1 = 1'b0; #1;
        m_install(32'h80, 32'h12345678);
        total++; if (to || ga !== 32'h80 || gw !== 1'b0) begin bad++; $display("FAIL evict_req got a=%h we=%b to=%b exp a=00000080 we=0", ga, gw, to); end
        total++; if (data_ready1 !== 1'b1 || data_response1 !== m_read(32'h80)) begin
            bad++; $display("FAIL evict_hit got r=%b d=%h exp r=1 d=%h", data_ready1, data_response1, m_read(32'h80)); end
        lookup_addr = 32'h40; #1;
        total++; if (data_ready1 !== m_hit(32'h40) || data_response1 !== m_read(32'h40)) begin
            bad++; $display("FAIL evict_old got r=%b d=%h exp r=%b d=%h", data_ready1, data_response1, m_hit(32'h40), m_read(32'h40)); end
        data_missed1 = 1'b1; tick();
        serve_read(32'hDEADBEEF, 1, 1, ga, gw, to);
        data_missed1 = 1'b0; #1;
        m_install(32'h40, 32'hDEADBEEF);
        total++; if (to || data_ready1 !== 1'b1 || data_response1 !== m_read(32'h40)) begin
            bad++; $display("FAIL refill got r=%b d=%h exp r=1 d=%h", data_ready1, data_response1, m_read(32'h40)); end
    endtask

    task automatic test_store();
        logic [31:0] ga, gd;
        logic gw;
        bit to;
        lookup_addr = 32'h40; st_valid = 1'b1; st_addr = 32'h40; st_data = 32'hCAFEF00D; #1;
        total++; if (st_ready !== 1'b1) begin bad++; $display("FAIL st_ready_hit got=%b exp=1", st_ready); end
        tick(); st_valid = 1'b0; #1;
        m_store(32'h40, 32'hCAFEF00D);
        total++; if (data_ready1 !== 1'b1 || data_response1 !== m_read(32'h40)) begin
            bad++; $display("FAIL st_update got r=%b d=%h exp r=1 d=%h", data_ready1, data_response1, m_read(32'h40)); end
        total++; if (st_ready !== 1'b0) begin bad++; $display("FAIL st_ready_busy got=%b exp=0", st_ready); end
        serve_write(0, ga, gw, gd, to);
        total++; if (to || ga !== 32'h40 || gw !== 1'b1 || gd !== 32'hCAFEF00D) begin
            bad++; $display("FAIL st_memwr got a=%h we=%b d=%h exp a=00000040 we=1 d=cafef00d", ga, gw, gd); end
        st_valid = 1'b1; st_addr = 32'h102; st_data = 32'h0BADF00D; tick(); st_valid = 1'b0;
        serve_write(2, ga, gw, gd, to);
        m_store(32'h102, 32'h0BADF00D);
        total++; if (to || ga !== 32'h100 || gw !== 1'b1 || gd !== 32'h0BADF00D) begin
            bad++; $display("FAIL st_miss_memwr got a=%h we=%b d=%h exp a=00000100 we=1 d=0badf00d", ga, gw, gd); end
        lookup_addr = 32'h100; #1;
        total++; if (data_ready1 !== m_hit(32'h100)) begin bad++; $display("FAIL st_no_alloc got=%b exp=%b", data_ready1, m_hit(32'h100)); end
        lookup_addr = 32'h40; #1;
        total++; if (data_response1 !== m_read(32'h40)) begin bad++; $display("FAIL st_keep got=%h exp=%h", data_response1, m_read(32'h40)); end
    endtask

    task automatic test_priority();
        logic [31:0] ga, gd;
        logic gw;
        bit to;
        lookup_addr = 32'h300; data_missed1 = 1'b1;
        st_valid = 1'b1; st_addr = 32'h44; st_data = 32'h11112222; #1;
        total++; if (st_ready !== 1'b0) begin bad++; $display("FAIL prio_st_ready got=%b exp=0", st_ready); end
        tick();
        serve_read(32'h33334444, 0, 2, ga, gw, to);
        m_install(32'h300, 32'h33334444);
        total++; if (to || ga !== 32'h300 || gw !== 1'b0) begin bad++; $display("FAIL prio_read got a=%h we=%b exp a=00000300 we=0", ga, gw); end
        #1;
        total++; if (st_ready !== 1'b1) begin bad++; $display("FAIL prio_st_after got=%b exp=1", st_ready); end
        tick(); st_valid = 1'b0; data_missed1 = 1'b0;
        serve_write(0, ga, gw, gd, to);
        m_store(32'h44, 32'h11112222);
        total++; if (to || ga !== 32'h44 || gw !== 1'b1 || gd !== 32'h11112222) begin
            bad++; $display("FAIL prio_write got a=%h we=%b d=%h exp a=00000044 we=1 d=11112222", ga, gw, gd); end
        lookup_addr = 32'h44; #1;
        total++; if (data_ready1 !== m_hit(32'h44)) begin bad++; $display("FAIL prio_no_alloc got=%b exp=%b", data_ready1, m_hit(32'h44)); end
    endtask

    task automatic test_stall_reset();
        lookup_addr = 32'h500; data_missed1 = 1'b1; tick();
        for (int i = 0; i < 5; i++) begin
            total++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h500 || mem_req_we !== 1'b0) begin
                bad++; $display("FAIL stall_hold%0d got v=%b a=%h we=%b exp v=1 a=00000500 we=0", i, mem_req_valid, mem_req_addr, mem_req_we); end
            tick();
        end
        mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
        data_missed1 = 1'b0;
        reset = 1'b0; tick(); reset = 1'b1;
        m_clear();
        mem_resp_valid = 1'b1; mem_resp_data = 32'h55AA55AA; tick(); mem_resp_valid = 1'b0; #1;
        total++; if (mem_req_valid !== 1'b0 || st_ready !== 1'b1) begin
            bad++; $display("FAIL rstmid_idle got v=%b st_ready=%b exp v=0 st_ready=1", mem_req_valid, st_ready); end
        total++; if (data_ready1 !== 1'b0 || data_response1 !== 32'h0) begin
            bad++; $display("FAIL rstmid_noinstall got r=%b d=%h exp r=0 d=0", data_ready1, data_response1); end
        lookup_addr = 32'h300; #1;
        total++; if (data_ready1 !== 1'b0) begin bad++; $display("FAIL rstmid_inval got=%b exp=0", data_ready1); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 150; i++) begin
            logic [31:0] a, d, ga, gd;
            logic gw;
            bit to;
            a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 2) == 0) begin
                d = $urandom;
                lookup_addr = a; st_valid = 1'b1; st_addr = a; st_data = d; #1;
                total++; if (st_ready !== 1'b1) begin bad++; $display("FAIL rnd_st_ready[%0d] got=%b exp=1", i, st_ready); end
                tick(); st_valid = 1'b0;
                serve_write($urandom_range(0, 3), ga, gw, gd, to);
                m_store(a, d);
                total++; if (to || ga !== (a & ~32'h3) || gw !== 1'b1 || gd !== d) begin
                    bad++; $display("FAIL rnd_wr[%0d] got a=%h we=%b d=%h exp a=%h we=1 d=%h", i, ga, gw, gd, a & ~32'h3, d); end
                #1;
                total++; if (data_ready1 !== m_hit(a) || data_response1 !== m_read(a)) begin
                    bad++; $display("FAIL rnd_st_look[%0d] got r=%b d=%h exp r=%b d=%h", i, data_ready1, data_response1, m_hit(a), m_read(a)); end
            end else begin
                lookup_addr = a; data_missed1 = 1'b0; #1;
                total++; if (data_ready1 !== m_hit(a) || data_response1 !== m_read(a)) begin
                    bad++; $display("FAIL rnd_look[%0d] got r=%b d=%h exp r=%b d=%h", i, data_ready1, data_response1, m_hit(a), m_read(a)); end
                if (!m_hit(a)) begin
                    d = mem_model.exists(a >> 2) ? mem_model[a >> 2] : $urandom;
                    mem_model[a >> 2] = d;
                    data_missed1 = 1'b1; tick();
                    serve_read(d, $urandom_range(0, 3), $urandom_range(1, 4), ga, gw, to);
                    data_missed1 = 1'b0; #1;
                    m_install(a, d);
                    total++; if (to || ga !== (a & ~32'h3) || gw !== 1'b0 || data_ready1 !== 1'b1 || data_response1 !== d) begin
                        bad++; $display("FAIL rnd_fill[%0d] got a=%h we=%b r=%b d=%h exp a=%h we=0 r=1 d=%h", i, ga, gw, data_ready1, data_response1, a & ~32'h3, d); end
                end
            end
        end
    endtask

`ifdef DCACHE_STATS_EN
    task automatic test_stats();
        logic [31:0] ga;
        logic gw;
        bit to;
        lookup_addr = 32'h08; apply_reset();
        total++; if (stat_hits !== 32'd0 || stat_misses !== 32'd0) begin
            bad++; $display("FAIL stats_reset got h=%0d m=%0d exp 0 0", stat_hits, stat_misses); end
        lookup_addr = 32'h40; data_missed1 = 1'b1; tick();
        serve_read(32'hA, 0, 1, ga, gw, to);
        lookup_addr = 32'h84; tick();
        serve_read(32'hB, 0, 2, ga, gw, to);
        lookup_addr = 32'h08; data_missed1 = 1'b0; #1;
        total++; if (stat_misses !== 32'd2 || stat_hits !== 32'd0) begin
            bad++; $display("FAIL stats_miss got h=%0d m=%0d exp 0 2", stat_hits, stat_misses); end
        lookup_addr = 32'h40;
        repeat (3) tick();
        lookup_addr = 32'h08; tick();
        total++; if (stat_hits !== 32'd3 || stat_misses !== 32'd2) begin
            bad++; $display("FAIL stats_hit got h=%0d m=%0d exp 3 2", stat_hits, stat_misses); end
    endtask
`endif

    initial begin
        test_reset();
        test_fill_basic();
        test_evict();
        test_store();
        test_priority();
        test_stall_reset();
        test_random();
`ifdef DCACHE_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
